// File: rtl/sym_clk_divider.sv
// Divide-by-N word clock generator running on the C-PHY symbol clock.
// Tracks word alignment from AlignReq through a HUNT/TRACK/LOCK state machine.
module sym_clk_divider #(
  parameter int DIV_WIDTH     = 4,
  parameter int DEFAULT_RATIO = 7,
  parameter int LOCK_WORDS    = 3
) (
  input  logic                 SymClk,
  input  logic                 RstN,
  input  logic                 Enable,
  input  logic [DIV_WIDTH-1:0] Ratio,
  input  logic                 AlignReq,
  output logic                 WordClk,
  output logic                 WordStrobe,
  output logic [DIV_WIDTH-1:0] SymIndex,
  output logic                 Locked,
  output logic                 Slip,
  output logic                 RatioErr
);

  localparam int GW = (LOCK_WORDS < 2) ? 1 : $clog2(LOCK_WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_TRACK = 2'd2,
    ST_LOCK  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_nsh;
  logic [GW-1:0]        r_good;
  logic                 r_word_clk;
  logic                 r_word_strobe;
  logic                 r_locked;
  logic                 r_slip;
  logic                 r_ratio_err;

  state_t               w_state_next;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic [DIV_WIDTH-1:0] w_nsh_next;
  logic [GW-1:0]        w_good_next;
  logic                 w_err_next;
  logic                 w_slip_next;
  logic                 w_wrap;
  logic                 w_misalign;
  logic                 w_ratio_bad;
  logic [DIV_WIDTH-1:0] w_ratio_samp;
  logic [DIV_WIDTH:0]   w_half;
  logic                 w_word_clk_next;
  logic                 w_word_strobe_next;
  logic                 w_locked_next;

  // Ratios below 2 cannot form a word; clamp to 2 and flag it.
  assign w_ratio_bad  = (Ratio < DIV_WIDTH'(2));
  assign w_ratio_samp = w_ratio_bad ? DIV_WIDTH'(2) : Ratio;
  assign w_wrap       = (r_cnt == r_nsh - 1'b1);
  assign w_misalign   = AlignReq && !w_wrap;

  // State register
  always_ff @(posedge SymClk or negedge RstN) begin
    if (!RstN) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_nsh         <= DIV_WIDTH'(DEFAULT_RATIO);
      r_good        <= '0;
      r_word_clk    <= 1'b0;
      r_word_strobe <= 1'b0;
      r_locked      <= 1'b0;
      r_slip        <= 1'b0;
      r_ratio_err   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_nsh         <= w_nsh_next;
      r_good        <= w_good_next;
      r_word_clk    <= w_word_clk_next;
      r_word_strobe <= w_word_strobe_next;
      r_locked      <= w_locked_next;
      r_slip        <= w_slip_next;
      r_ratio_err   <= w_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_nsh_next   = r_nsh;
    w_good_next  = r_good;
    w_err_next   = r_ratio_err;
    w_slip_next  = 1'b0;
    if (!Enable) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_good_next  = '0;
      w_err_next   = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_state_next = ST_HUNT;
      w_cnt_next   = '0;
      w_good_next  = '0;
      w_nsh_next   = w_ratio_samp;
      w_err_next   = r_ratio_err | w_ratio_bad;
    end else begin
      w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        w_nsh_next = w_ratio_samp;
        w_err_next = r_ratio_err | w_ratio_bad;
      end
      case (r_state)
        ST_HUNT: begin
          if (AlignReq) begin
            w_cnt_next   = '0;
            w_good_next  = '0;
            w_state_next = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_misalign) begin
            w_cnt_next  = '0;
            w_good_next = '0;
          end else if (w_wrap) begin
            if (r_good == GW'(LOCK_WORDS - 1)) begin
              w_good_next  = '0;
              w_state_next = ST_LOCK;
            end else begin
              w_good_next = r_good + 1'b1;
            end
          end
        end
        ST_LOCK: begin
          if (w_misalign) begin
            w_cnt_next   = '0;
            w_good_next  = '0;
            w_slip_next  = 1'b1;
            w_state_next = ST_TRACK;
          end else if (w_wrap && (w_ratio_samp != r_nsh)) begin
            w_good_next  = '0;
            w_state_next = ST_TRACK;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: derived from next count/ratio so all outputs move on the same edge
  assign w_half = ({1'b0, w_nsh_next} + (DIV_WIDTH+1)'(1)) >> 1;

  always_comb begin
    w_word_clk_next    = 1'b0;
    w_word_strobe_next = 1'b0;
    w_locked_next      = 1'b0;
    if (w_state_next != ST_IDLE) begin
      w_word_clk_next    = ({1'b0, w_cnt_next} < w_half);
      w_word_strobe_next = (w_cnt_next == w_nsh_next - 1'b1);
      w_locked_next      = (w_state_next == ST_LOCK);
    end
  end

  assign WordClk    = r_word_clk;
  assign WordStrobe = r_word_strobe;
  assign SymIndex   = r_cnt;
  assign Locked     = r_locked;
  assign Slip       = r_slip;
  assign RatioErr   = r_ratio_err;

endmodule

// File: tb/tb_sym_clk_divider.sv
// Directed bench for sym_clk_divider: free-run, align/lock, slip, ratio change,
// invalid ratio, Enable drop and asynchronous reset.
module tb_sym_clk_divider;

  logic       SymClk;
  logic       RstN;
  logic       Enable;
  logic [3:0] Ratio;
  logic       AlignReq;
  logic       WordClk;
  logic       WordStrobe;
  logic [3:0] SymIndex;
  logic       Locked;
  logic       Slip;
  logic       RatioErr;

  int n_cmp = 0;
  int n_err = 0;

  sym_clk_divider #(
    .DIV_WIDTH    (4),
    .DEFAULT_RATIO(7),
    .LOCK_WORDS   (3)
  ) dut (
    .SymClk    (SymClk),
    .RstN      (RstN),
    .Enable    (Enable),
    .Ratio     (Ratio),
    .AlignReq  (AlignReq),
    .WordClk   (WordClk),
    .WordStrobe(WordStrobe),
    .SymIndex  (SymIndex),
    .Locked    (Locked),
    .Slip      (Slip),
    .RatioErr  (RatioErr)
  );

  initial SymClk = 1'b0;
  always #5 SymClk = ~SymClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge SymClk);
    #1;
  endtask

  // Expected word outputs for index idx within a word of n symbols.
  task automatic exp_cyc(input int idx, input int n, input bit lk);
    $display("t=%0t idx=%0d clk=%0b stb=%0b lock=%0b slip=%0b err=%0b (exp idx=%0d n=%0d lock=%0b)",
             $time, SymIndex, WordClk, WordStrobe, Locked, Slip, RatioErr, idx, n, lk);
    check("SymIndex", 32'(SymIndex), 32'(idx));
    check("WordClk", 32'(WordClk), 32'(idx < (n + 1) / 2));
    check("WordStrobe", 32'(WordStrobe), 32'(idx == n - 1));
    check("Locked", 32'(Locked), 32'(lk));
    check("Slip", 32'(Slip), 32'd0);
  endtask

  task automatic exp_zero(input string tag);
    $display("t=%0t %s idx=%0d clk=%0b stb=%0b lock=%0b slip=%0b err=%0b",
             $time, tag, SymIndex, WordClk, WordStrobe, Locked, Slip, RatioErr);
    check({tag, "_idx"}, 32'(SymIndex), 32'd0);
    check({tag, "_clk"}, 32'(WordClk), 32'd0);
    check({tag, "_stb"}, 32'(WordStrobe), 32'd0);
    check({tag, "_lock"}, 32'(Locked), 32'd0);
    check({tag, "_slip"}, 32'(Slip), 32'd0);
    check({tag, "_err"}, 32'(RatioErr), 32'd0);
  endtask

  initial begin
    RstN = 1'b0; Enable = 1'b0; Ratio = 4'd7; AlignReq = 1'b0;
    repeat (2) step();
    exp_zero("reset");
    RstN = 1'b1;
    step();
    exp_zero("idle");

    // Free-running HUNT at N=7
    Enable = 1'b1;
    for (int k = 0; k < 14; k++) begin step(); exp_cyc(k % 7, 7, 1'b0); end
    for (int k = 0; k < 4; k++) begin step(); exp_cyc(k, 7, 1'b0); end

    // Align at index 3, then three clean words to lock
    AlignReq = 1'b1; step(); AlignReq = 1'b0;
    exp_cyc(0, 7, 1'b0);
    for (int k = 1; k <= 21; k++) begin step(); exp_cyc(k % 7, 7, k == 21); end

    // Consistent AlignReq at index 6 is ignored
    for (int k = 1; k <= 6; k++) begin step(); exp_cyc(k, 7, 1'b1); end
    AlignReq = 1'b1; step(); AlignReq = 1'b0;
    exp_cyc(0, 7, 1'b1);

    // Misaligned AlignReq at index 2 -> slip
    for (int k = 1; k <= 2; k++) begin step(); exp_cyc(k, 7, 1'b1); end
    AlignReq = 1'b1; step(); AlignReq = 1'b0;
    $display("t=%0t slip idx=%0d slip=%0b lock=%0b", $time, SymIndex, Slip, Locked);
    check("slip_pulse", 32'(Slip), 32'd1);
    check("slip_idx", 32'(SymIndex), 32'd0);
    check("slip_lock", 32'(Locked), 32'd0);
    check("slip_clk", 32'(WordClk), 32'd1);
    check("slip_stb", 32'(WordStrobe), 32'd0);
    for (int k = 1; k <= 21; k++) begin step(); exp_cyc(k % 7, 7, k == 21); end

    // Ratio 7 -> 5 mid-word: current word finishes at 7, relock on N=5
    for (int k = 1; k <= 3; k++) begin step(); exp_cyc(k, 7, 1'b1); end
    Ratio = 4'd5;
    for (int k = 4; k <= 6; k++) begin step(); exp_cyc(k, 7, 1'b1); end
    for (int k = 0; k <= 15; k++) begin step(); exp_cyc(k % 5, 5, k == 15); end

    // Invalid ratio: clamps to 2, sticky error
    Ratio = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      step(); exp_cyc(k, 5, 1'b1);
      check("err_before", 32'(RatioErr), 32'd0);
    end
    step(); exp_cyc(0, 2, 1'b0);
    check("err_set", 32'(RatioErr), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      step(); exp_cyc(k % 2, 2, 1'b0);
      check("err_sticky", 32'(RatioErr), 32'd1);
    end

    // Enable drop with AlignReq pulsing: IDLE, everything cleared
    Enable = 1'b0; AlignReq = 1'b1;
    step(); exp_zero("en_low");
    step(); exp_zero("idle_align");
    AlignReq = 1'b0; Ratio = 4'd7;

    // Restart, then asynchronous reset mid-word
    Enable = 1'b1;
    for (int k = 0; k <= 3; k++) begin step(); exp_cyc(k, 7, 1'b0); end
    RstN = 1'b0;
    #2;
    exp_zero("async_rst");
    Enable = 1'b0;
    step();
    RstN = 1'b1;
    step();
    exp_zero("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sym_clk_divider.md
Name: sym_clk_divider

Overview:
- Synthesizable divide-by-N word-clock generator for the C-PHY datapath. It runs on the symbol clock and produces a word-rate clock plus a one-cycle word strobe, nominally one word per 7 symbols.
- Phase alignment comes from a sync/preamble detector (AlignReq). The block tracks alignment with a lock state machine, so downstream word logic knows when word boundaries are trustworthy.

Parameters:
- DIV_WIDTH, 4, width of the ratio field and the symbol counter.
- DEFAULT_RATIO, 7, divide ratio loaded at reset (7 symbols per 16-bit word).
- LOCK_WORDS, 3, number of consecutive clean words required in TRACK before LOCK.

Ports:
- SymClk  input  1  symbol clock; all logic is posedge.
- RstN  input  1  asynchronous, active-low reset.
- Enable  input  1  run the divider; low forces IDLE.
- Ratio  input  DIV_WIDTH  requested divide ratio N; valid range 2..2^DIV_WIDTH-1.
- AlignReq  input  1  single-cycle pulse: the current symbol is the first symbol of a word.
- WordClk  output  1  divided clock, registered.
- WordStrobe  output  1  one-cycle pulse on the last symbol of each word.
- SymIndex  output  DIV_WIDTH  position of the current symbol within the word, 0..N-1.
- Locked  output  1  high in the LOCK state.
- Slip  output  1  one-cycle pulse when a misaligned AlignReq arrives in LOCK.
- RatioErr  output  1  sticky flag: an invalid Ratio was sampled. Cleared only by reset or Enable low.

Behaviour:
- Reset: all outputs 0; state IDLE; shadow ratio = DEFAULT_RATIO; good-word counter = 0.
- All outputs are flops.
  - SymIndex is the counter itself.
  - WordStrobe = (SymIndex == Nsh-1).
  - WordClk = (SymIndex < (Nsh+1)>>1).
  - These are computed from the next-state count, so all three change on the same edge. For N=7: WordClk is high for indices 0..3 and low for 4..6.
- Shadow ratio Nsh:
  - Ratio is sampled on entry to HUNT and at every wrap (SymIndex == Nsh-1).
  - If Ratio < 2, Nsh = 2 and RatioErr is set.
  - Ratio changes mid-word have no effect until the wrap.
- Counter: increments each cycle in HUNT, TRACK and LOCK; at Nsh-1 it wraps to 0.
- States:
  - IDLE: counter = 0, WordClk = 0, WordStrobe = 0. Enable=1 -> HUNT (counter starts at 0 on the next cycle).
  - HUNT: free-running, Locked = 0. AlignReq -> next SymIndex = 0; good-word counter = 0; go to TRACK.
  - TRACK:
    - Each wrap without a misaligned AlignReq increments the good-word counter.
    - Reaching LOCK_WORDS -> LOCK (Locked high on the same edge the count wraps to 0).
    - AlignReq while SymIndex != Nsh-1: realign (next SymIndex = 0) and good-word counter = 0; stay in TRACK.
  - LOCK:
    - AlignReq while SymIndex == Nsh-1 is consistent and ignored.
    - AlignReq at any other index: Slip = 1 for one cycle, realign to 0, Locked = 0, go to TRACK with good-word counter = 0.
    - If a wrap samples a Nsh different from the previous value: go to TRACK with good-word counter = 0.
- Consistent AlignReq in TRACK (at SymIndex == Nsh-1): not a realign; the word still counts as clean.
- Priority: RstN > Enable low > AlignReq > normal count.
  - Enable low in any state -> IDLE next edge; outputs and RatioErr cleared.
  - AlignReq in IDLE is ignored.
- Realign cycle: WordStrobe is not asserted for the truncated word. The next edge after the AlignReq edge shows SymIndex = 0 and WordClk = 1.
- Async reset mid-word: immediate return to reset values. After release, wait for Enable.

Test Plan:
- Reset, Enable=1, Ratio=7, no AlignReq -> SymIndex cycles 0..6; WordStrobe every 7th cycle; WordClk 4 high / 3 low; Locked=0.
- AlignReq at SymIndex=3 in HUNT, then consistent words -> next SymIndex=0; Locked rises at the start of the 4th word (LOCK_WORDS=3); no Slip.
- In LOCK, AlignReq at SymIndex=6 -> no change. AlignReq at SymIndex=2 -> Slip pulse; Locked=0; SymIndex=0 next cycle; relocks after 3 clean words.
- Ratio changed 7->5 mid-word in LOCK -> current word completes at 7; next word has period 5 (WordClk 3 high / 2 low); Locked drops and re-asserts after 3 words.
- Ratio=1 -> Nsh=2; RatioErr=1 and stays set; Enable low clears it.
- RstN asserted mid-word, and Enable dropped while AlignReq pulses -> all outputs 0 immediately (async) or on the next edge (Enable); state IDLE; AlignReq ignored.
